qf100_spi_flash_master: RTL and testbench



---
 rtl/qf100_spi_pkg.sv | 32 +++
 rtl/qf100_spi_sclk_gen.sv | 41 ++++
 rtl/qf100_spi_flash_master.sv | 186 ++++++++++++++++++
 tb/tb_qf100_spi_flash_master.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qf100_spi_pkg.sv
// Shared constants and state type for the QF100 SPI flash read master.
// Build option QF100_SPI_FLASH_SEQ_EN adds the SEQ_IDLE continuation state.
package qf100_spi_pkg;

  localparam logic [7:0] READ_CMD  = 8'h03;
  localparam int         CMD_BITS  = 8;
  localparam int         ADDR_BITS = 24;
  localparam int         DATA_BITS = 32;
  localparam int         XFER_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;

  localparam logic [5:0] LAST_CMD_BIT   = 6'(CMD_BITS - 1);
  localparam logic [5:0] LAST_ADDR_BIT  = 6'(CMD_BITS + ADDR_BITS - 1);
  localparam logic [5:0] FIRST_DATA_BIT = 6'(CMD_BITS + ADDR_BITS);
  localparam logic [5:0] LAST_BIT       = 6'(XFER_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DESEL
`ifdef QF100_SPI_FLASH_SEQ_EN
    , ST_SEQ_IDLE
`endif
  } state_e;

  // Word address of the following fetch; wraps the same way the flash does.
  function automatic logic [21:0] next_word(input logic [21:0] w);
    return w + 22'd1;
  endfunction

endpackage

// File: rtl/qf100_spi_sclk_gen.sv
// SCLK generator: CLK_DIV cycles low then CLK_DIV cycles high while enabled.
// rise_o/fall_o flag the CLK edge at which SCLK toggles; skip_i starts a run one low cycle in.
module qf100_spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic skip_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  logic [3:0] cnt_q;
  logic       sclk_q;
  logic       active;
  logic       last;

  assign active = en_i | skip_i;
  assign last   = (cnt_q == 4'(CLK_DIV - 1));
  assign rise_o = active & last & ~sclk_q;
  assign fall_o = active & last & sclk_q;
  assign sclk_o = sclk_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (!active) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (last) begin
      cnt_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      cnt_q  <= cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/qf100_spi_flash_master.sv
// SPI mode-0 flash word-fetch master issuing 0x03 READ; one 32-bit little-endian word per request.
// Build option QF100_SPI_FLASH_SEQ_EN keeps CSB low after a fetch so the next sequential word skips CMD/ADDR.
module qf100_spi_flash_master #(
  parameter int CLK_DIV  = 2,
  parameter int CSB_HIGH = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        spi_csb,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  import qf100_spi_pkg::*;

  state_e      state_q;
  logic [63:0] shreg_q;
  logic [5:0]  bit_q;
  logic [5:0]  bit_d;
  logic [6:0]  asm_q;
  logic [7:0]  desel_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        csb_q;
  logic [31:0] rsp_data_q;

  logic        sclk;
  logic        rise;
  logic        fall;
  logic        xfer;
  logic        accept;
  logic        seq_hit;
  logic        sample;
  logic [5:0]  sample_bit;
  logic [7:0]  byte_d;
  logic        unused_addr_lsb;

  // Byte-offset bits never reach the wire: fetches are always word aligned.
  assign unused_addr_lsb = ^req_addr[1:0];

`ifdef QF100_SPI_FLASH_SEQ_EN
  logic [21:0] addr_q;
  logic [21:0] next_q;
  logic        pend_q;

  assign seq_hit = (state_q == ST_SEQ_IDLE) && accept && (req_addr[23:2] == next_q);
`else
  assign seq_hit = 1'b0;
`endif

  assign xfer       = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign accept     = req_valid & req_ready_q;
  assign sample     = rise & ((state_q == ST_DATA) | seq_hit);
  assign sample_bit = seq_hit ? FIRST_DATA_BIT : bit_q;
  assign byte_d     = {asm_q, spi_miso};
  assign bit_d      = bit_q + 6'd1;

  qf100_spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk_i (CLK),
    .rst_ni(RST_N),
    .en_i  (xfer),
    .skip_i(seq_hit),
    .sclk_o(sclk),
    .rise_o(rise),
    .fall_o(fall)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bit_q       <= '0;
      asm_q       <= '0;
      desel_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      csb_q       <= 1'b1;
      rsp_data_q  <= '0;
`ifdef QF100_SPI_FLASH_SEQ_EN
      addr_q      <= '0;
      next_q      <= '0;
      pend_q      <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;

      // A sequential hit with CLK_DIV=1 takes its first sample on the accept edge itself.
      if (sample) begin
        asm_q <= byte_d[6:0];
        if (sample_bit[2:0] == 3'd7) begin
          rsp_data_q[{sample_bit[4:3], 3'b000} +: 8] <= byte_d;
        end
      end

      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q <= 1'b0;
            csb_q       <= 1'b0;
            bit_q       <= '0;
            shreg_q     <= {READ_CMD, req_addr[23:2], 2'b00, 32'h0};
            state_q     <= ST_CMD;
`ifdef QF100_SPI_FLASH_SEQ_EN
            addr_q      <= req_addr[23:2];
`endif
          end
        end

        ST_CMD, ST_ADDR, ST_DATA: begin
          if (fall) begin
            shreg_q <= {shreg_q[62:0], 1'b0};
            bit_q   <= bit_d;
            if (bit_q == LAST_CMD_BIT)  state_q <= ST_ADDR;
            if (bit_q == LAST_ADDR_BIT) state_q <= ST_DATA;
            if (bit_q == LAST_BIT) begin
              rsp_valid_q <= 1'b1;
`ifdef QF100_SPI_FLASH_SEQ_EN
              state_q     <= ST_SEQ_IDLE;
              req_ready_q <= 1'b1;
              next_q      <= next_word(addr_q);
`else
              state_q     <= ST_DESEL;
              csb_q       <= 1'b1;
              desel_q     <= 8'(CSB_HIGH);
`endif
            end
          end
        end

        ST_DESEL: begin
          if (desel_q != 8'd0) begin
            desel_q <= desel_q - 8'd1;
`ifdef QF100_SPI_FLASH_SEQ_EN
          end else if (pend_q) begin
            pend_q  <= 1'b0;
            csb_q   <= 1'b0;
            bit_q   <= '0;
            shreg_q <= {READ_CMD, addr_q, 2'b00, 32'h0};
            state_q <= ST_CMD;
`endif
          end else begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
          end
        end

`ifdef QF100_SPI_FLASH_SEQ_EN
        // The flash is still streaming; a hit resumes clocking at the next data bit.
        ST_SEQ_IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            addr_q      <= req_addr[23:2];
            if (seq_hit) begin
              bit_q   <= FIRST_DATA_BIT;
              state_q <= ST_DATA;
            end else begin
              csb_q   <= 1'b1;
              desel_q <= 8'(CSB_HIGH - 1);
              pend_q  <= 1'b1;
              state_q <= ST_DESEL;
            end
          end
        end
`endif

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign spi_csb   = csb_q;
  assign spi_sclk  = sclk;
  assign spi_mosi  = shreg_q[63];

endmodule

// File: tb/tb_qf100_spi_flash_master.sv
// Bench for qf100_spi_flash_master: behavioural SPI flash, word-level reference model, random fetches.
// Works for both the default build and QF100_SPI_FLASH_SEQ_EN.
module tb_qf100_spi_flash_master;

  localparam int CLK_DIV  = 2;
  localparam int CSB_HIGH = 4;

  logic        CLK       = 1'b0;
  logic        RST_N     = 1'b1;
  logic        req_valid = 1'b0;
  logic [23:0] req_addr  = '0;
  logic        spi_miso  = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        spi_csb;
  logic        spi_sclk;
  logic        spi_mosi;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_rsp = 0;

  always #5 CLK = ~CLK;

  qf100_spi_flash_master #(
    .CLK_DIV (CLK_DIV),
    .CSB_HIGH(CSB_HIGH)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .spi_csb  (spi_csb),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always @(posedge CLK) begin
    cyc++;
    if (rsp_valid) n_rsp++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural SPI flash ----------------
  logic [7:0]  mem [int];
  logic [31:0] seed;
  logic [31:0] fin      = '0;
  logic [31:0] last_hdr = '0;
  logic [23:0] fptr     = '0;
  int          fbits     = 0;
  int          hdr_cnt   = 0;
  int          csb_rises = 0;
  int          rise_cyc  = 0;
  int          last_gap  = 0;
  logic        p_sclk    = 1'b0;
  logic        p_csb     = 1'b1;

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    logic [31:0] h;
    if (mem.exists(int'(a))) return mem[int'(a)];
    h = ({8'h00, a} ^ seed) * 32'h9E3779B1;
    return h[31:24];
  endfunction

  always @(spi_sclk or spi_csb) begin
    logic [7:0] b;
    int idx;
    if (spi_csb !== p_csb) begin
      fbits = 0;
      if (spi_csb === 1'b1) begin
        csb_rises++;
        rise_cyc = cyc;
      end else begin
        last_gap = cyc - rise_cyc;
      end
    end else if (spi_csb === 1'b0 && spi_sclk === 1'b1 && p_sclk === 1'b0) begin
      if (fbits < 32) fin = {fin[30:0], spi_mosi};
      fbits++;
      if (fbits == 32) begin
        last_hdr = fin;
        hdr_cnt++;
        fptr = fin[23:0];
      end
    end else if (spi_csb === 1'b0 && spi_sclk === 1'b0 && p_sclk === 1'b1) begin
      if (fbits >= 32) begin
        idx = fbits - 32;
        b = fbyte(24'(fptr + 24'(idx / 8)));
        spi_miso = b[7 - (idx % 8)];
      end
    end
    p_sclk = spi_sclk;
    p_csb  = spi_csb;
  end

  // ---------------- reference model ----------------
  bit          m_open     = 1'b0;
  logic [23:0] m_next     = '0;
  bit          have_prev  = 1'b0;
  int          last_rsp_c = 0;

  task automatic do_fetch(input logic [23:0] addr);
    logic [23:0] wa;
    logic [31:0] exp_d;
    int exp_lat, acc_c, rsp_c, h0, r0, n;
    bit exp_seq, got;
    wa      = {addr[23:2], 2'b00};
    exp_d   = {fbyte(wa + 24'd3), fbyte(wa + 24'd2), fbyte(wa + 24'd1), fbyte(wa)};
    exp_seq = m_open && (wa == m_next);
    if (exp_seq)     exp_lat = 64 * CLK_DIV;
    else if (m_open) exp_lat = CSB_HIGH + 1 + 128 * CLK_DIV;
    else             exp_lat = 1 + 128 * CLK_DIV;
    h0 = hdr_cnt;
    r0 = csb_rises;
    acc_c = 0;
    rsp_c = 0;

    @(negedge CLK);
    req_valid = 1'b1;
    req_addr  = addr;
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      if (req_ready) got = 1'b1;
      else begin
        @(negedge CLK);
        n++;
      end
    end
    chk("accept_seen", 64'(got), 64'd1);
    if (!got) begin
      req_valid = 1'b0;
      return;
    end
    acc_c = cyc;
`ifndef QF100_SPI_FLASH_SEQ_EN
    if (have_prev) chk("b2b_accept_spacing", 64'((acc_c - last_rsp_c) >= CSB_HIGH + 1), 64'd1);
`endif
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    req_addr  = 24'($urandom);

    got = 1'b0;
    n = 0;
    while (!got && n < 3000) begin
      @(negedge CLK);
      n++;
      if (rsp_valid) begin
        got = 1'b1;
        rsp_c = cyc;
      end
    end
    chk("rsp_seen", 64'(got), 64'd1);
    if (!got) return;
    chk("latency", 64'(rsp_c - acc_c), 64'(exp_lat));
    chk("rsp_data", 64'(rsp_data), 64'(exp_d));
    if (exp_seq) begin
      chk("seq_no_cmd", 64'(hdr_cnt - h0), 64'd0);
      chk("seq_csb_low", 64'(csb_rises - r0), 64'd0);
    end else begin
      chk("cmd_count", 64'(hdr_cnt - h0), 64'd1);
      chk("cmd_addr_bits", 64'(last_hdr), 64'({8'h03, wa}));
      if (have_prev) chk("csb_high_gap", 64'(last_gap >= CSB_HIGH), 64'd1);
    end
    @(negedge CLK);
    chk("rsp_one_cycle", 64'(rsp_valid), 64'd0);
    chk("rsp_data_hold", 64'(rsp_data), 64'(exp_d));
    last_rsp_c = rsp_c;
    have_prev  = 1'b1;
`ifdef QF100_SPI_FLASH_SEQ_EN
    m_open = 1'b1;
    m_next = wa + 24'd4;
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [23:0] a;
    int n, n0, sel;
    bit got;
    seed = $urandom;
    mem[32'h100] = 8'h11;
    mem[32'h101] = 8'h22;
    mem[32'h102] = 8'h33;
    mem[32'h103] = 8'h44;

    #1 RST_N = 1'b0;
    repeat (10) @(negedge CLK);
    chk("rst_csb", 64'(spi_csb), 64'd1);
    chk("rst_sclk", 64'(spi_sclk), 64'd0);
    chk("rst_mosi", 64'(spi_mosi), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle_req_ready", 64'(req_ready), 64'd1);

    do_fetch(24'h000100);
    chk("tp_hdr_0100", 64'(last_hdr), 64'h03000100);
    chk("tp_data_0100", 64'(rsp_data), 64'h44332211);
    do_fetch(24'h000103);
    chk("tp_data_0103", 64'(rsp_data), 64'h44332211);
    do_fetch(24'h000000);
    do_fetch(24'h000200);
    do_fetch(24'h000100);
    do_fetch(24'h000104);
    do_fetch(24'h000000);
    do_fetch(24'hFFFFFC);
    do_fetch(24'h000000);

    for (int k = 0; k < 12; k++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      a = m_next | 24'($urandom_range(0, 3));
      else if (sel == 1) a = 24'hFFFFFC;
      else               a = 24'($urandom);
      do_fetch(a);
    end

    // Abort a fetch part-way through the address phase.
    @(negedge CLK);
    req_valid = 1'b1;
    req_addr  = 24'h000300;
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      if (req_ready) got = 1'b1;
      else begin
        @(negedge CLK);
        n++;
      end
    end
    @(posedge CLK);
    #1 req_valid = 1'b0;
    n = 0;
    while (fbits < 16 && n < 500) begin
      @(negedge CLK);
      n++;
    end
    chk("abort_in_addr", 64'(fbits >= 16 && fbits < 32), 64'd1);
    n0 = n_rsp;
    #2 RST_N = 1'b0;
    #1;
    chk("abort_csb_async", 64'(spi_csb), 64'd1);
    repeat (5) @(negedge CLK);
    chk("abort_sclk", 64'(spi_sclk), 64'd0);
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd0);
    chk("abort_rsp_data", 64'(rsp_data), 64'd0);
    RST_N = 1'b1;
    m_open    = 1'b0;
    have_prev = 1'b0;
    repeat (300) @(negedge CLK);
    chk("abort_no_rsp", 64'(n_rsp - n0), 64'd0);
    do_fetch(24'h000101);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "time limit");
  end

endmodule
